// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer for the MEM stage of the pipelined core.
// Issues one req/ack transaction per load/store and stalls the pipeline until it completes.
// Optional feature macro: DMEM_TIMEOUT_EN adds an REQ-state timeout with a sticky Err_o.
module dmem_access_ctrl #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] Addr_i,
  input  logic [DATA_W-1:0] WData_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              Stall_o,
  output logic [DATA_W-1:0] RData_o,
  output logic              Err_o
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES) > 5) ? $clog2(TIMEOUT_CYCLES) : 5;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            expired;

  // Counter is zero outside REQ, so it is already cleared on REQ entry.
  always_comb begin
    cnt_d   = (state_q == StReq) ? cnt_q + CntW'(1) : '0;
    expired = (state_q == StReq) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  end

  // Timeout counter and sticky error flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign Err_o = err_q;
`else
  assign Err_o = 1'b0;
`endif

  // Next-state and datapath capture for the access FSM.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef DMEM_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (MemRead_i || MemWrite_i) begin
          state_d = StReq;
          we_d    = MemWrite_i;  // read+write together is a write
          addr_d  = Addr_i;
          wdata_d = WData_i;
        end
      end
      StReq: begin
        // Ack wins over a simultaneous timeout expiry.
        if (mem_ack_i) begin
          if (!we_q) rdata_d = mem_rdata_i;
          state_d = StDone;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (expired) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end
`endif
      end
      StDone: state_d = StIdle;  // controls seen here belong to the completed access
      default: state_d = StIdle;
    endcase
  end

  // State and request registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Stall is gated by reset so the pipeline is never held frozen while reset is asserted.
  always_comb begin
    Stall_o = rst_i && (((state_q == StIdle) && (MemRead_i || MemWrite_i)) ||
                        (state_q == StReq));
  end

  assign mem_req_o   = (state_q == StReq);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign RData_o     = rdata_q;

endmodule
